// File: rtl/pattern_match_pkg.sv
// Shared types and defaults for the serial pattern matcher controller.
package pattern_match_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_TO_W  = 16;

  // A pattern length is usable only in 1..pat_w.
  function automatic logic len_legal(input int len, input int pat_w);
    return (len != 0) && (len <= pat_w);
  endfunction

endpackage

// File: rtl/pattern_shift_cmp.sv
// History shift register with fill tracking and a length-masked compare.
// hit is combinational for the current shift cycle.
module pattern_shift_cmp
  import pattern_match_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             in_bit,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_next;

  always_comb begin
    hist_next = {hist[PAT_W-2:0], in_bit};
    fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift && (fill_next >= len) && ((hist_next & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_next;
      // Without overlap the next match must be built from fresh bits only.
      fill <= (hit && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/pattern_match_ctrl.sv
// Run-time controller: config handshake, arm/abort FSM, match and timeout counting.
// Outputs are registered; match_pulse lags the qualifying in_valid cycle by one clock.
module pattern_match_ctrl
  import pattern_match_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TO_W  = DEF_TO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             cfg_overlap,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             timeout_flag,
  output logic             err
);

  state_t           state;
  state_t           state_next;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] target_q;
  logic [TO_W-1:0]  timeout_q;
  logic             overlap_q;
  logic             cfg_valid_q;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_cnt_next;
  logic [CNT_W-1:0] count_next;
  logic             idle;
  logic             armed;
  logic             shift;
  logic             hit;
  logic             arm;
  logic             cfg_take;
  logic             cfg_ok;
  logic             tgt_hit;
  logic             to_hit;

  assign idle      = (state == IDLE);
  assign armed     = (state == ARMED);
  assign cfg_ready = idle;
  assign busy      = armed;
  assign done      = (state == DONE);
  assign cfg_take  = cfg_valid && idle;
  assign cfg_ok    = len_legal(int'(cfg_len), PAT_W);
  assign shift     = armed && in_valid && !abort;

  pattern_shift_cmp #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_cmp (
    .clk    (clk),
    .rst    (rst),
    .clear  (arm),
    .shift  (shift),
    .in_bit (in_bit),
    .overlap(overlap_q),
    .pattern(pat_q),
    .len    (len_q),
    .hit    (hit)
  );

  assign count_next  = (hit && (match_count != '1)) ? match_count + CNT_W'(1) : match_count;
  assign to_cnt_next = to_cnt + TO_W'(1);
  assign tgt_hit     = hit && (target_q != '0) && (count_next == target_q);
  assign to_hit      = (timeout_q != '0) && (to_cnt_next == timeout_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    arm        = 1'b0;
    case (state)
      IDLE:  if (start && cfg_valid_q) begin state_next = ARMED; arm = 1'b1; end
      ARMED: if (tgt_hit || to_hit) state_next = DONE;
      DONE:  if (start) begin state_next = ARMED; arm = 1'b1; end
      default: state_next = IDLE;
    endcase
    // abort overrides every other transition, including a re-arm.
    if (abort) begin
      state_next = IDLE;
      arm        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q        <= '0;
      len_q        <= '0;
      target_q     <= '0;
      timeout_q    <= '0;
      overlap_q    <= 1'b0;
      cfg_valid_q  <= 1'b0;
      to_cnt       <= '0;
      match_count  <= '0;
      match_pulse  <= 1'b0;
      timeout_flag <= 1'b0;
      err          <= 1'b0;
    end else begin
      match_pulse <= hit;
      if (cfg_take) begin
        if (cfg_ok) begin
          pat_q       <= cfg_pattern;
          len_q       <= cfg_len;
          target_q    <= cfg_target;
          timeout_q   <= cfg_timeout;
          overlap_q   <= cfg_overlap;
          cfg_valid_q <= 1'b1;
          err         <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (idle && start && !cfg_valid_q) err <= 1'b1;
      if (abort) err <= 1'b0;
      if (arm) begin
        match_count  <= '0;
        to_cnt       <= '0;
        timeout_flag <= 1'b0;
      end else if (armed && !abort) begin
        match_count <= count_next;
        to_cnt      <= to_cnt_next;
        if (to_hit && !tgt_hit) timeout_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Bench for pattern_match_ctrl: vector table, corner sequences, random run against a queue model.
module tb_pattern_match_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid, cfg_ready, cfg_overlap;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic [15:0] cfg_target, cfg_timeout;
  logic        start, abort, in_valid, in_bit;
  logic        busy, match_pulse, done, timeout_flag, err;
  logic [15:0] match_count;

  int total = 0;
  int bad   = 0;

  pattern_match_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_target(cfg_target),
    .cfg_timeout(cfg_timeout), .cfg_overlap(cfg_overlap), .start(start),
    .abort(abort), .in_valid(in_valid), .in_bit(in_bit), .busy(busy),
    .match_pulse(match_pulse), .match_count(match_count), .done(done),
    .timeout_flag(timeout_flag), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [15:0] tgt;
    logic [15:0] tmo;
    logic        ov;
    logic [15:0] stream;   // first bit sent is stream[nbits-1]
    int          nbits;
    logic [15:0] pmask;    // bit i: pulse expected after bit i
    logic [15:0] ecount;
    logic        edone;
  } vec_t;

  vec_t vecs[5];

  // Reference model state
  logic       m_armed, m_done, m_cfgq, m_err, m_tflag, m_pulse, m_ov;
  int         m_count, m_to, m_len, m_tgt, m_tmo;
  logic [7:0] m_pat;
  bit         m_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic [15:0] tgt,
                           input logic [15:0] tmo, input logic ov);
    cfg_pattern = pat; cfg_len = len; cfg_target = tgt; cfg_timeout = tmo; cfg_overlap = ov;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    in_valid = 1'b1;
    for (int b = 0; b < n; b++) begin
      in_bit = bits[n-1-b];
      tick();
    end
    in_valid = 1'b0;
  endtask

  function automatic bit window_matches();
    int sz;
    sz = m_hist.size();
    if (sz < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_hist[sz-m_len+k] != m_pat[m_len-1-k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_done = 0; m_cfgq = 0; m_err = 0; m_tflag = 0; m_pulse = 0; m_ov = 0;
    m_count = 0; m_to = 0; m_len = 0; m_tgt = 0; m_tmo = 0; m_pat = '0;
    m_hist.delete();
  endtask

  // One clock of the controller's rules applied to the current inputs.
  task automatic model_step();
    bit idle_now;
    bit cfgq_old;
    bit hit;
    idle_now = !m_armed && !m_done;
    cfgq_old = m_cfgq;
    hit      = 1'b0;
    m_pulse  = 1'b0;
    if (idle_now && cfg_valid) begin
      if (cfg_len >= 1 && cfg_len <= 8) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_tgt = int'(cfg_target);
        m_tmo = int'(cfg_timeout); m_ov = cfg_overlap; m_cfgq = 1'b1; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (abort) begin
      m_err = 1'b0; m_armed = 1'b0; m_done = 1'b0;
    end else if (m_armed) begin
      m_to++;
      if (in_valid) begin
        m_hist.push_back(in_bit);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        if (window_matches()) begin
          hit = 1'b1;
          if (!m_ov) m_hist.delete();
        end
      end
      if (hit) begin
        if (m_count < 65535) m_count++;
        m_pulse = 1'b1;
      end
      if (hit && m_tgt != 0 && m_count == m_tgt) begin
        m_armed = 1'b0; m_done = 1'b1;
      end else if (m_tmo != 0 && m_to == m_tmo) begin
        m_armed = 1'b0; m_done = 1'b1; m_tflag = 1'b1;
      end
    end else if (start && (m_done || cfgq_old)) begin
      m_armed = 1'b1; m_done = 1'b0; m_count = 0; m_to = 0; m_tflag = 1'b0;
      m_hist.delete();
    end else if (start && idle_now) begin
      m_err = 1'b1;
    end
  endtask

  initial begin
    cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0; cfg_timeout = '0;
    cfg_overlap = 0; start = 0; abort = 0; in_valid = 0; in_bit = 0;

    vecs[0] = '{pat:8'h35, len:4'd6, tgt:16'd2, tmo:16'd0, ov:1'b0, stream:16'b0000_1101_0111_0101,
                nbits:12, pmask:16'h0820, ecount:16'd2, edone:1'b1};
    vecs[1] = '{pat:8'h05, len:4'd3, tgt:16'd0, tmo:16'd0, ov:1'b1, stream:16'h0015,
                nbits:5, pmask:16'h0014, ecount:16'd2, edone:1'b0};
    vecs[2] = '{pat:8'h05, len:4'd3, tgt:16'd0, tmo:16'd0, ov:1'b0, stream:16'h0015,
                nbits:5, pmask:16'h0004, ecount:16'd1, edone:1'b0};
    vecs[3] = '{pat:8'hA5, len:4'd8, tgt:16'd0, tmo:16'd0, ov:1'b0, stream:16'hA5A5,
                nbits:16, pmask:16'h8080, ecount:16'd2, edone:1'b0};
    vecs[4] = '{pat:8'h01, len:4'd1, tgt:16'd3, tmo:16'd0, ov:1'b0, stream:16'h000B,
                nbits:4, pmask:16'h000D, ecount:16'd3, edone:1'b1};

    tick(); tick();
    rst = 1'b0;
    check("rst cfg_ready", 32'(cfg_ready), 1);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst pulse", 32'(match_pulse), 0);
    check("rst count", 32'(match_count), 0);
    check("rst tflag", 32'(timeout_flag), 0);
    check("rst err", 32'(err), 0);

    // start without a legal config, then illegal lengths keep the stored config
    start = 1; tick(); start = 0;
    check("nocfg err", 32'(err), 1);
    check("nocfg idle", 32'({busy, cfg_ready}), 32'b01);
    configure(8'h05, 4'd3, 16'd0, 16'd0, 1'b1);
    check("legal clears err", 32'(err), 0);
    configure(8'hFF, 4'd0, 16'd1, 16'd0, 1'b0);
    check("len0 err", 32'(err), 1);
    configure(8'hFF, 4'd9, 16'd1, 16'd0, 1'b0);
    check("len9 err", 32'(err), 1);
    start = 1; tick(); start = 0;
    check("kept cfg arms", 32'(busy), 1);
    send_bits(16'h0005, 3);
    check("kept cfg match", 32'(match_pulse), 1);
    check("err sticky armed", 32'(err), 1);
    abort = 1; tick(); abort = 0;
    check("abort clears err", 32'({err, busy}), 0);

    for (int v = 0; v < 5; v++) begin
      abort = 1; tick(); abort = 0;
      configure(vecs[v].pat, vecs[v].len, vecs[v].tgt, vecs[v].tmo, vecs[v].ov);
      start = 1; tick(); start = 0;
      check($sformatf("vec%0d busy", v), 32'(busy), 1);
      in_valid = 1;
      for (int b = 0; b < vecs[v].nbits; b++) begin
        in_bit = vecs[v].stream[vecs[v].nbits-1-b];
        tick();
        check($sformatf("vec%0d pulse%0d", v, b), 32'(match_pulse), 32'(vecs[v].pmask[b]));
      end
      in_valid = 0;
      check($sformatf("vec%0d count", v), 32'(match_count), 32'(vecs[v].ecount));
      check($sformatf("vec%0d done", v), 32'(done), 32'(vecs[v].edone));
      check($sformatf("vec%0d tflag", v), 32'(timeout_flag), 0);
    end

    // timeout exactly 10 ARMED cycles after start, no matching bits
    abort = 1; tick(); abort = 0;
    configure(8'hFF, 4'd8, 16'd5, 16'd10, 1'b0);
    in_valid = 1; in_bit = 0;
    start = 1; tick(); start = 0;
    repeat (9) tick();
    check("timeout early", 32'(done), 0);
    tick();
    check("timeout done", 32'({done, timeout_flag, busy}), 32'b110);
    check("timeout count", 32'(match_count), 0);
    in_valid = 0;

    // match and timeout on the same cycle: target reached wins, otherwise timeout
    for (int t = 1; t <= 2; t++) begin
      abort = 1; tick(); abort = 0;
      configure(8'h01, 4'd1, 16'(t), 16'd3, 1'b0);
      start = 1; tick(); start = 0;
      send_bits(16'h0001, 3);
      check($sformatf("tie%0d done", t), 32'(done), 1);
      check($sformatf("tie%0d tflag", t), 32'(timeout_flag), (t == 1) ? 0 : 1);
      check($sformatf("tie%0d count", t), 32'(match_count), 1);
    end

    // abort beats start (from DONE and from IDLE) and beats a completing match
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    check("abort+start done", 32'({busy, done, cfg_ready}), 32'b001);
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    check("abort+start idle", 32'({busy, done}), 0);
    configure(8'h05, 4'd3, 16'd1, 16'd0, 1'b1);
    start = 1; tick(); start = 0;
    send_bits(16'h0002, 2);
    in_valid = 1; in_bit = 1; abort = 1; tick(); abort = 0; in_valid = 0;
    check("abort match state", 32'({busy, done, match_pulse}), 0);
    check("abort match count", 32'(match_count), 0);
    tick();
    check("abort match late pulse", 32'(match_pulse), 0);

    // async reset between edges while a pulse is showing
    configure(8'h05, 4'd3, 16'd0, 16'd0, 1'b1);
    start = 1; tick(); start = 0;
    send_bits(16'h0005, 3);
    check("pre-rst pulse", 32'({busy, match_pulse}), 32'b11);
    #2 rst = 1'b1;
    #1;
    check("async rst outs", 32'({cfg_ready, busy, done, match_pulse, timeout_flag, err}), 32'b100000);
    check("async rst count", 32'(match_count), 0);
    #1 rst = 1'b0;
    tick();
    start = 1; tick(); start = 0;
    check("post-rst needs cfg", 32'({busy, err}), 32'b01);

    // randomized run against the reference model
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom_range(0, 9));
      cfg_target  = 16'($urandom_range(0, 4));
      cfg_timeout = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(3, 40));
      cfg_overlap = 1'($urandom_range(0, 1));
      start       = ($urandom_range(0, 7) == 0);
      abort       = ($urandom_range(0, 49) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_bit      = 1'($urandom_range(0, 1));
      model_step();
      tick();
      check($sformatf("rand c%0d", c),
            {10'd0, cfg_ready, busy, done, match_pulse, timeout_flag, err, match_count},
            {10'd0, !m_armed && !m_done, m_armed, m_done, m_pulse, m_tflag, m_err, 16'(m_count)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
